// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 8;

    typedef logic [DEF_DATA_W-1:0] reg_word_t;

    // Address width for a register count; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Priority select over the write ports for one target address: reports whether
// any enabled port hits it and which data wins.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = 3,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    // Ascending scan: a later (higher-index) port overrides earlier matches.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, optional write->read bypass
// and a per-register pending scoreboard for RAW hazard detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_RD  = 3,
    parameter int NUM_WR  = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW     = addr_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr_in,
    output logic [NUM_RD*DATA_W-1:0] rd_data_out,
    output logic [NUM_RD-1:0]        rd_ready_out,
    input  logic [NUM_WR-1:0]        wr_en_in,
    input  logic [NUM_WR*AW-1:0]     wr_addr_in,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_in,
    input  logic                     alloc_en_in,
    input  logic [AW-1:0]            alloc_addr_in,
    output logic [DEPTH-1:0]         pending_out
);

    // Registers that accept writes and allocations (r0 is hard-wired when ZERO_R0).
    localparam logic [DEPTH-1:0] LIVE = ZERO_R0 ? ~DEPTH'(1) : '1;

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] wr_sel   [DEPTH];
    logic [DATA_W-1:0] byp_data [NUM_RD];
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  set;
    logic [DEPTH-1:0]  clr;
    logic [DEPTH-1:0]  pending;
    logic [NUM_RD-1:0] byp_hit;

    for (genvar r = 0; r < DEPTH; r++) begin : g_wr
        regfile_wr_arb #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NUM_WR (NUM_WR)
        ) u_arb (
            .wr_en   (wr_en_in),
            .wr_addr (wr_addr_in),
            .wr_data (wr_data_in),
            .addr    (AW'(r)),
            .hit     (wr_hit[r]),
            .data    (wr_sel[r])
        );
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_byp
        regfile_wr_arb #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NUM_WR (NUM_WR)
        ) u_byp (
            .wr_en   (wr_en_in),
            .wr_addr (wr_addr_in),
            .wr_data (wr_data_in),
            .addr    (rd_addr_in[j*AW +: AW]),
            .hit     (byp_hit[j]),
            .data    (byp_data[j])
        );
    end

    always_comb begin
        set = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            set[r] = LIVE[r] && alloc_en_in && (alloc_addr_in == AW'(r));
        end
        clr = wr_hit & LIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (wr_hit[r] && LIVE[r]) begin
                    regs[r] <= wr_sel[r];
                end
            end
            // A new allocation outranks the old producer's result landing the same edge.
            pending <= set | (pending & ~clr);
        end
    end

    // Outputs are forced idle while in reset so bypassed write data cannot leak out.
    always_comb begin
        rd_data_out  = '0;
        rd_ready_out = '1;
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            if (rst_n && !(ZERO_R0 && (rd_addr_in[j*AW +: AW] == '0))) begin
                if (BYPASS && byp_hit[j]) begin
                    rd_data_out[j*DATA_W +: DATA_W] = byp_data[j];
                    rd_ready_out[j]                 = 1'b1;
                end else begin
                    rd_data_out[j*DATA_W +: DATA_W] = regs[rd_addr_in[j*AW +: AW]];
                    rd_ready_out[j]                 = !pending[rd_addr_in[j*AW +: AW]];
                end
            end
        end
    end

    assign pending_out = pending;

endmodule
